// File: rtl/alu_issue_unit.sv
// alu_issue_unit: issues one instruction at a time to an external ALU.
// It owns a 4 x 8-bit register file. It drives the ALU operands and the op
// select, then writes the ALU result back. Each op goes IDLE -> EXEC -> WB,
// so the unit accepts at most one op every three cycles.
module alu_issue_unit (
    input  logic       CLK,
    input  logic       RST,
    input  logic       InValid,
    output logic       InReady,
    input  logic [3:0] InFunSel,
    input  logic [1:0] InDst,
    input  logic [1:0] InSrcA,
    input  logic [1:0] InSrcB,
    input  logic       LdEn,
    input  logic [1:0] LdAddr,
    input  logic [7:0] LdData,
    input  logic [1:0] RdAddr,
    output logic [7:0] RdData,
    output logic [7:0] A,
    output logic [7:0] B,
    output logic [3:0] FunSel,
    input  logic [7:0] OutALU,
    input  logic [3:0] ZCNO,
    output logic [7:0] Result,
    output logic [3:0] Flags,
    output logic       Done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    // Compare produces flags only and never writes its destination register.
    localparam logic [3:0] OP_CMP = 4'b0110;

    state_t     state_q, state_d;
    logic [3:0] fun_q, fun_d;
    logic [1:0] dst_q, dst_d;
    logic [1:0] srca_q, srca_d;
    logic [1:0] srcb_q, srcb_d;
    logic [7:0] result_q, result_d;
    logic [3:0] flags_q, flags_d;
    logic       done_q, done_d;
    logic [7:0] regs_q [4];
    logic [7:0] regs_d [4];

    logic busy;
    logic accept;

    assign busy    = (state_q == EXEC) || (state_q == WB);
    assign InReady = (state_q == IDLE) && !RST;
    assign accept  = InValid && InReady;

    // Next state, op capture, preload and write-back.
    always_comb begin
        state_d  = state_q;
        fun_d    = fun_q;
        dst_d    = dst_q;
        srca_d   = srca_q;
        srcb_d   = srcb_q;
        result_d = result_q;
        flags_d  = flags_q;
        done_d   = 1'b0;
        regs_d   = regs_q;
        case (state_q)
            IDLE: begin
                // A preload and an accept can share an edge. The op reads
                // the preloaded value in EXEC because the operands come
                // from the register file after that edge.
                if (LdEn) begin
                    regs_d[LdAddr] = LdData;
                end
                if (accept) begin
                    fun_d   = InFunSel;
                    dst_d   = InDst;
                    srca_d  = InSrcA;
                    srcb_d  = InSrcB;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                // The ALU registers its flags at this edge.
                state_d = WB;
            end
            WB: begin
                result_d = OutALU;
                flags_d  = ZCNO;
                if (fun_q != OP_CMP) begin
                    regs_d[dst_q] = OutALU;
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and op registers. Reset aborts any op in flight.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            fun_q    <= 4'b0000;
            dst_q    <= 2'd0;
            srca_q   <= 2'd0;
            srcb_q   <= 2'd0;
            result_q <= 8'h00;
            flags_q  <= 4'b0000;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            fun_q    <= fun_d;
            dst_q    <= dst_d;
            srca_q   <= srca_d;
            srcb_q   <= srcb_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            done_q   <= done_d;
        end
    end

    // Register file, one flop bank per entry.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_rf
            // Entry gi: cleared on reset, otherwise follows its next value.
            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    regs_q[gi] <= 8'h00;
                end else begin
                    regs_q[gi] <= regs_d[gi];
                end
            end
        end
    endgenerate

    // Operands are held for both EXEC and WB and are forced to zero when idle.
    assign A      = busy ? regs_q[srca_q] : 8'h00;
    assign B      = busy ? regs_q[srcb_q] : 8'h00;
    assign FunSel = busy ? fun_q : 4'b0000;
    assign RdData = regs_q[RdAddr];
    assign Result = result_q;
    assign Flags  = flags_q;
    assign Done   = done_q;

endmodule

// File: doc/alu_issue_unit.md
ALU_ISSUE_UNIT -- requirements
Module: alu_issue_unit

Interface
REQ-001 Parameters: none; register file fixed at 4 x 8 bits (R0-R3).
REQ-002 CLK  input  1  system clock; all state updates on rising edge.
REQ-003 RST  input  1  reset, asynchronous, active-high.
REQ-004 InValid  input  1  instruction offered.
REQ-005 InReady  output  1  unit accepts an instruction this cycle.
REQ-006 InFunSel  input  4  ALU operation code, same encoding the ALU uses (0000 A ... 1111 CSR).
REQ-007 InDst, InSrcA, InSrcB  input  2 each  destination and source register indices.
REQ-008 LdEn  input  1  preload strobe; LdAddr  input  2; LdData  input  8.
REQ-009 RdAddr  input  2; RdData  output  8  combinational read of R[RdAddr].
REQ-010 A, B  output  8 each  ALU operands; FunSel  output  4  ALU operation select.
REQ-011 OutALU  input  8  ALU result; ZCNO  input  4  ALU registered flags {Z,C,N,O}.
REQ-012 Result  output  8  last written-back result; Flags  output  4  last captured ZCNO.
REQ-013 Done  output  1  one-cycle completion pulse.

Function
REQ-014 FSM states IDLE, EXEC, WB; IDLE->EXEC on InValid&&InReady; EXEC->WB unconditionally; WB->IDLE unconditionally.
REQ-015 InReady = 1 only in IDLE and RST low; handshake transfer at rising edge with InValid=InReady=1.
REQ-016 On transfer: latch InFunSel, InDst, InSrcA, InSrcB into internal op register; input fields ignored at all other times.
REQ-017 IDLE: A=0x00, B=0x00, FunSel=0000.
REQ-018 EXEC and WB: A=R[SrcA], B=R[SrcB], FunSel=latched op, held stable across both cycles.
REQ-019 WB edge (EXEC->WB edge has latched ZCNO in the ALU): capture OutALU into Result, ZCNO into Flags.
REQ-020 WB edge: write OutALU into R[Dst], except latched op 0110 (compare) -> no register write; Result/Flags still update.
REQ-021 Done = 1 exactly in the cycle following the WB edge, 0 otherwise.
REQ-022 Latency: accept edge t0 -> R[Dst]/Result/Flags valid and Done high after edge t0+2; next accept earliest at t0+3; throughput one op per 3 cycles.
REQ-023 Preload: LdEn in IDLE writes LdData into R[LdAddr] at the edge; LdEn in EXEC/WB ignored.
REQ-024 LdEn and a transfer at the same edge: both take effect; the accepted op reads the preloaded value in EXEC.
REQ-025 InValid held high while busy: no second capture; the offer is accepted at the first IDLE edge.
REQ-026 Src==Dst legal; sources read before writeback (operands stable until the WB edge).
REQ-027 RdData reflects a write from the cycle after the writing edge.

Reset
REQ-028 RST high: state=IDLE, R0-R3=0x00, op register=0, Result=0x00, Flags=0000, Done=0, InReady=0, A=B=0x00, FunSel=0000.
REQ-029 RST asserted in EXEC or WB: op aborted, no register write, no Done pulse.
REQ-030 After RST deasserts: InReady=1 from the first cycle.

Verification
REQ-031 Reset mid-EXEC: preload R1=0x05, issue ADD, assert RST in EXEC -> R0-R3=0x00, Done never pulses, InReady=1 after release.
REQ-032 ADD: R1=0x05, R2=0x03, op 0100 Dst=R3 -> Done after 2 edges, R3=0x08, Result=0x08, Flags=0000.
REQ-033 SUB to zero: op 0101 SrcA=SrcB=R1 (0x05), Dst=R0 -> R0=0x00, Result=0x00, Flags=1000.
REQ-034 Compare: op 0110 SrcA=R1 (0x05), SrcB=R2 (0x03), Dst=R2 -> R2 stays 0x03, Result=OutALU, Flags updated, Done pulses.
REQ-035 Back-to-back: InValid held for two ops -> accept edges exactly 3 cycles apart, InReady=0 in EXEC/WB, two Done pulses.
REQ-036 LdEn=1, LdAddr=R1, LdData=0xFF during EXEC -> R1 unchanged; same strobe in IDLE -> RdData(R1)=0xFF next cycle.
